// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: two-digit time-multiplexed scan scheduler for a shared hex-to-7-segment decoder.
// Ports: clk (rising edge), reset (sync, active high), s0/s1 (digit nibbles),
//        hex_out (nibble to shared decoder), anode (active-low digit enables, [0]=digit 0),
//        digit_sel (digit owned or pending), frame_tick (last cycle of each scan frame).
// Optional: define SEG_SCAN_DEADTIME_EN to insert BLANK-cycle dead time after each digit.
module seg_scan_ctrl #(
    parameter int PERIOD = 48000,
    parameter int BLANK  = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] s0,
    input  logic [3:0] s1,
    output logic [3:0] hex_out,
    output logic [1:0] anode,
    output logic       digit_sel,
    output logic       frame_tick
);
    localparam int MAXC = PERIOD > BLANK ? PERIOD : BLANK;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] P_LAST = CW'(PERIOD - 1);
    typedef enum logic [1:0] {SHOW0, BLANK0, SHOW1, BLANK1} state_t;
    state_t state, nxt;
    logic [CW-1:0] cnt;
    logic [3:0] hex_q;
    logic last;
`ifdef SEG_SCAN_DEADTIME_EN
    localparam logic [CW-1:0] B_LAST = CW'(BLANK - 1);
    assign last = cnt == ((state == SHOW0 || state == SHOW1) ? P_LAST : B_LAST);
    assign nxt = state == SHOW0 ? BLANK0 :
                 state == BLANK0 ? SHOW1 :
                 state == SHOW1 ? BLANK1 : SHOW0;
    assign frame_tick = state == BLANK1 && cnt == B_LAST;
`else
    assign last = cnt == P_LAST;
    assign nxt = state == SHOW0 ? SHOW1 : SHOW0;
    assign frame_tick = state == SHOW1 && last;
`endif
    assign hex_out = hex_q;
    assign anode = state == SHOW0 ? 2'b10 : state == SHOW1 ? 2'b01 : 2'b11;
    // digit_sel points at the digit being shown or about to be shown
    assign digit_sel = state == BLANK0 || state == SHOW1;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SHOW0;
            cnt   <= '0;
            hex_q <= 4'h0;
        end else if (last) begin
            state <= nxt;
            cnt   <= '0;
            // nibble is captured only on entry to a SHOW state
            if (nxt == SHOW0)
                hex_q <= s0;
            else if (nxt == SHOW1)
                hex_q <= s1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule
